// File: rtl/serialize_word_to_bit_stream_fsm.sv
// Parallel-word to MSB-first serial bit stream with valid/ready upload and gapless word chaining.
// Optional macro SERIALIZER_PARITY_EN appends one even-parity bit after each word.
module serialize_word_to_bit_stream_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             bit_d;
  logic             vld_d;

  // cnt is the index of the bit currently presented on bit_out
  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign accept   = up_valid && up_ready;

`ifdef SERIALIZER_PARITY_EN
  logic parity, parity_d;
  assign up_ready = (state == IDLE) || (state == PARITY);
`else
  assign up_ready = (state == IDLE) || last_bit;
`endif

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = up_data;
          cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^up_data;
`endif
        end
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            sreg_d = up_data;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          sreg_d = {sreg[WIDTH-2:0], 1'b0};
          cnt_d  = cnt + CW'(1);
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d  = SHIFT;
          sreg_d   = up_data;
          cnt_d    = '0;
          parity_d = ^up_data;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state will present
  always_comb begin
    vld_d = (state_d != IDLE);
    bit_d = 1'b0;
    if (state_d == SHIFT) bit_d = sreg_d[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
    if (state_d == PARITY) bit_d = parity_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      cnt       <= cnt_d;
      bit_out   <= bit_d;
      bit_valid <= vld_d;
      busy      <= vld_d;
`ifdef SERIALIZER_PARITY_EN
      parity    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serialize_word_to_bit_stream_fsm.sv
// Bench for serialize_word_to_bit_stream_fsm (WIDTH=8, default build): vector table, corner sequences, random vs queue model.
module tb_serialize_word_to_bit_stream_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic [7:0] up_data;
  logic       up_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  serialize_word_to_bit_stream_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       b;
    logic       bv;
    logic       bs;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one posedge pass, return at the following negedge
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    rst = r;
    up_valid = v;
    up_data = d;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic b, input logic bv, input logic bs);
    chk({tag, ".up_ready"}, 32'(up_ready), 32'(rdy));
    chk({tag, ".bit_out"}, 32'(bit_out), 32'(b));
    chk({tag, ".bit_valid"}, 32'(bit_valid), 32'(bv));
    chk({tag, ".busy"}, 32'(busy), 32'(bs));
  endtask

  // Word w1 accepted from idle, w2 offered continuously until taken; expect 16 gapless bits
  task automatic back_to_back(input string tag, input logic [7:0] w1, input logic [7:0] w2);
    logic [15:0] exp16;
    exp16 = {w1, w2};
    cycle(1'b0, 1'b1, w1);
    chk_all({tag, "[0]"}, 1'b0, exp16[15], 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, (i <= 8), w2);
      chk_all($sformatf("%s[%0d]", tag, i), (i == 7 || i == 15), exp16[15-i], 1'b1, 1'b1);
    end
    cycle(1'b0, 1'b0, 8'h00);
    chk_all({tag, ".end"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  bit q[$];
  logic       r_rnd, v_rnd;
  logic [7:0] d_rnd;
  bit         acc;

  initial begin
    rst = 1'b1;
    up_valid = 1'b0;
    up_data = 8'h00;

    // Single word 8'hCC, then idle, then rst colliding with up_valid
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d);
      chk_all($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].b, tbl[i].bv, tbl[i].bs);
    end

    back_to_back("b2b", 8'hCC, 8'h33);
    back_to_back("stall", 8'h0F, 8'hA5);

    // Reset at bit 3 of 8'hFF drops the word
    cycle(1'b0, 1'b1, 8'hFF);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, 8'h00);
    chk("rst_mid.before", 32'(bit_out), 32'd1);
    cycle(1'b1, 1'b1, 8'hFF);
    chk_all("rst_mid.after", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      chk($sformatf("rst_mid.quiet[%0d]", i), {30'd0, bit_out, bit_valid}, 32'd0);
    end

    // Random traffic against a bit-queue model: the queue holds the bits still to appear
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      r_rnd = ($urandom_range(0, 49) == 0);
      v_rnd = ($urandom_range(0, 9) < 6);
      d_rnd = 8'($urandom);
      acc = v_rnd && !r_rnd && (q.size() <= 1);
      cycle(r_rnd, v_rnd, d_rnd);
      if (r_rnd) begin
        q.delete();
      end else begin
        if (q.size() != 0) void'(q.pop_front());
        if (acc) for (int k = 7; k >= 0; k--) q.push_back(d_rnd[k]);
      end
      chk_all($sformatf("rnd[%0d]", n), (q.size() <= 1), (q.size() != 0) ? q[0] : 1'b0,
              (q.size() != 0), (q.size() != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
